// File: rtl/matrix_drv_pkg.sv
// Shared types and constants for the rotated 2x2 matrix-multiply driver.
// Provides the FSM state enum, frame/result sizing and the rotation helper.
package matrix_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    DONE
  } state_t;

  localparam int FRAME_BYTES  = 9;
  localparam int RESULT_WORDS = 4;
  localparam int ELEM_W       = 8;
  localparam int RES_W        = 17;

  localparam logic [1:0] ROT_ID  = 2'd0;
  localparam logic [1:0] ROT_CW  = 2'd1;
  localparam logic [1:0] ROT_180 = 2'd2;
  localparam logic [1:0] ROT_CCW = 2'd3;

  // Packing is row-major with x1 in the low byte.
  function automatic logic [4*ELEM_W-1:0] rotate(
    input logic [1:0]          code,
    input logic [4*ELEM_W-1:0] m
  );
    logic [ELEM_W-1:0] x1, x2, x3, x4;
    logic [4*ELEM_W-1:0] r;
    x1 = m[0*ELEM_W +: ELEM_W];
    x2 = m[1*ELEM_W +: ELEM_W];
    x3 = m[2*ELEM_W +: ELEM_W];
    x4 = m[3*ELEM_W +: ELEM_W];
    unique case (code)
      ROT_ID:  r = {x4, x3, x2, x1};
      ROT_CW:  r = {x2, x4, x1, x3};
      ROT_180: r = {x1, x2, x3, x4};
      ROT_CCW: r = {x3, x1, x4, x2};
      default: r = m;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/matrix_rot_golden.sv
// Combinational golden model: rotate A and B, then 2x2 unsigned multiply.
// Only instantiated when MATRIX_DRV_CHECK_EN is defined.
module matrix_rot_golden
  import matrix_drv_pkg::*;
(
  input  logic [1:0]              rot_a,
  input  logic [1:0]              rot_b,
  input  logic [4*ELEM_W-1:0]     mat_a,
  input  logic [4*ELEM_W-1:0]     mat_b,
  output logic [RESULT_WORDS*RES_W-1:0] expected
);

  logic [4*ELEM_W-1:0] ra;
  logic [4*ELEM_W-1:0] rb;

  function automatic logic [RES_W-1:0] dot(
    input logic [ELEM_W-1:0] p,
    input logic [ELEM_W-1:0] q,
    input logic [ELEM_W-1:0] r,
    input logic [ELEM_W-1:0] s
  );
    logic [2*ELEM_W-1:0] pq;
    logic [2*ELEM_W-1:0] rs;
    pq = (2*ELEM_W)'(p) * (2*ELEM_W)'(q);
    rs = (2*ELEM_W)'(r) * (2*ELEM_W)'(s);
    return RES_W'(pq) + RES_W'(rs);
  endfunction

  always_comb begin
    ra = rotate(rot_a, mat_a);
    rb = rotate(rot_b, mat_b);
    expected = '0;
    expected[0*RES_W +: RES_W] = dot(ra[7:0],   rb[7:0],
                                     ra[15:8],  rb[23:16]);
    expected[1*RES_W +: RES_W] = dot(ra[7:0],   rb[15:8],
                                     ra[15:8],  rb[31:24]);
    expected[2*RES_W +: RES_W] = dot(ra[23:16], rb[7:0],
                                     ra[31:24], rb[23:16]);
    expected[3*RES_W +: RES_W] = dot(ra[23:16], rb[15:8],
                                     ra[31:24], rb[31:24]);
  end

endmodule

// File: rtl/matrix_rot_driver.sv
// Initiator for the rotated 2x2 multiply byte protocol: 9-byte frame out,
// four 17-bit results in. Define MATRIX_DRV_CHECK_EN to enable golden checking.
module matrix_rot_driver
  import matrix_drv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    rot_a,
  input  logic [1:0]                    rot_b,
  input  logic [4*ELEM_W-1:0]           mat_a,
  input  logic [4*ELEM_W-1:0]           mat_b,
  output logic                          busy,
  output logic [ELEM_W-1:0]             tx_data,
  output logic                          tx_valid,
  input  logic [RES_W-1:0]              rx_data,
  input  logic                          rx_valid,
  output logic [RESULT_WORDS*RES_W-1:0] res,
  output logic                          done,
  output logic                          timeout,
  output logic                          short_burst,
  output logic                          pass,
  output logic                          fail
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FRAME_W = FRAME_BYTES * ELEM_W;

  state_t              state;
  logic [1:0]          ra_q;
  logic [1:0]          rb_q;
  logic [4*ELEM_W-1:0] ma_q;
  logic [4*ELEM_W-1:0] mb_q;
  logic [3:0]          bcnt;
  logic [1:0]          widx;
  logic [WAIT_W-1:0]   wcnt;
  logic [FRAME_W-1:0]  frame;
  logic [ELEM_W-1:0]   frame_byte;

  assign frame = {mb_q, ma_q, 4'b0, ra_q, rb_q};
  assign frame_byte = frame[bcnt*ELEM_W +: ELEM_W];

`ifdef MATRIX_DRV_CHECK_EN
  logic [RESULT_WORDS*RES_W-1:0] golden;
  logic                          match;

  matrix_rot_golden u_golden (
    .rot_a    (ra_q),
    .rot_b    (rb_q),
    .mat_a    (ma_q),
    .mat_b    (mb_q),
    .expected (golden)
  );

  // c3 is still on rx_data when the comparison is made.
  assign match = ({rx_data, res[3*RES_W-1:0]} == golden);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      bcnt        <= '0;
      widx        <= '0;
      wcnt        <= '0;
      busy        <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      res         <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      short_burst <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ra_q        <= rot_a;
            rb_q        <= rot_b;
            ma_q        <= mat_a;
            mb_q        <= mat_b;
            res         <= '0;
            timeout     <= 1'b0;
            short_burst <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            bcnt        <= '0;
            state       <= SEND;
          end
        end
        SEND: begin
          busy     <= 1'b1;
          tx_valid <= 1'b1;
          tx_data  <= frame_byte;
          bcnt     <= bcnt + 4'd1;
          if (bcnt == 4'(FRAME_BYTES - 1)) begin
            wcnt  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          tx_valid <= 1'b0;
          tx_data  <= '0;
          if (rx_valid) begin
            res[RES_W-1:0] <= rx_data;
            widx           <= 2'd1;
            state          <= RECV;
          end else if (wcnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            fail    <= 1'b1;
            state   <= DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RECV: begin
          if (!rx_valid) begin
            short_burst <= 1'b1;
            fail        <= 1'b1;
            state       <= DONE;
          end else begin
            res[widx*RES_W +: RES_W] <= rx_data;
            widx <= widx + 2'd1;
            if (widx == 2'(RESULT_WORDS - 1)) begin
`ifdef MATRIX_DRV_CHECK_EN
              pass <= match;
              fail <= !match;
`endif
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matrix_rot_driver.md
# matrix_rot_driver

Initiator side of the rotated 2x2 matrix-multiply byte protocol. Accepts a parallel job (two rotation codes, two 2x2 matrices of 8-bit elements), serializes it into the 9-byte frame the multiply responder consumes, then collects the responder's four 17-bit results. With checking compiled in, it also compares them against an internal golden model. Sits between a test/config controller and the multiply responder, in the same clock domain.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles from the last frame byte to the first rx_valid before abort.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- rot_a  in  2  rotation code for A
- rot_b  in  2  rotation code for B
- mat_a  in  32  A elements: [7:0]=a1, [15:8]=a2, [23:16]=a3, [31:24]=a4 (row-major)
- mat_b  in  32  B elements, same packing (b1..b4)
- busy  out  1  high from accept until done
- tx_data  out  8  frame byte to responder
- tx_valid  out  1  frame byte qualifier
- rx_data  in  17  result word from responder
- rx_valid  in  1  result qualifier
- res  out  68  captured results: c0 at [16:0], c1 at [33:17], c2 at [50:34], c3 at [67:51]
- done  out  1  one-cycle pulse at job end
- timeout  out  1  sticky until next accept: no response in time
- short_burst  out  1  sticky until next accept: rx_valid dropped before 4 words
- pass  out  1  sticky until next accept: all 4 results matched golden
- fail  out  1  sticky until next accept: mismatch, timeout or short_burst

## Operation
- States: IDLE, SEND, WAIT, RECV, DONE.
- IDLE: when start=1, latch rot_a, rot_b, mat_a and mat_b, clear res and all sticky flags, and go to SEND.
- SEND: 9 consecutive cycles with tx_valid=1.
  - Byte 0 = {4'b0, rot_a, rot_b}; rot_a is in bits [3:2].
  - Bytes 1–4 = a1..a4; bytes 5–8 = b1..b4.
  - After byte 8, go to WAIT with tx_valid=0 and tx_data=0.
- WAIT: count cycles. On rx_valid=1, capture c0 and go to RECV. If the count reaches TIMEOUT_CYCLES, set timeout and fail and go to DONE.
- RECV: capture c1, c2 and c3 on the next 3 cycles, which must all have rx_valid=1.
  - If rx_valid=0 on any of them, set short_burst and fail and go to DONE; words already captured remain in res.
  - After c3, compare (if checking is enabled) and go to DONE.
- DONE: pulse done for 1 cycle, then return to IDLE. res and the flags hold until the next accept.
- Rotation, applied to matrix [[x1,x2],[x3,x4]]:
  - Code 0: identity.
  - Code 1: (x1,x2,x3,x4) become (x3,x1,x4,x2).
  - Code 2: become (x4,x3,x2,x1).
  - Code 3: become (x2,x4,x1,x3).
- Golden results, using rotated A' and B':
  - c0 = a1·b1 + a2·b3
  - c1 = a1·b2 + a2·b4
  - c2 = a3·b1 + a4·b3
  - c3 = a3·b2 + a4·b4
- Arithmetic is unsigned. Products are 16 bits; each sum is 17 bits with no overflow possible (maximum 130050).
- start is ignored while busy=1. rx_valid is ignored in IDLE, SEND and DONE.
- A rx_valid that continues beyond 4 words is ignored.

## Timing
- Reset (asynchronous) returns the FSM to IDLE and forces every output to 0: busy, tx_valid, tx_data, res, done, timeout, short_burst, pass and fail. A reset mid-frame drops tx_valid immediately.
- Start is accepted at edge N. busy=1 and tx_valid=1 with byte 0 appear from edge N+1. Byte 8 is driven after edge N+9, and tx_valid=0 from edge N+10.
- rx_valid is sampled at each rising edge. The word captured at the edge where WAIT first sees rx_valid=1 is c0.
- done asserts on the cycle after the terminating event (c3 captured, timeout, or short burst). busy falls together with done.
- Minimum job time is 9 send cycles + 1 response cycle + 4 receive cycles + 1 done cycle.
- If start is held high across done, a new job is accepted the cycle after done.

## Configuration
- MATRIX_DRV_CHECK_EN defined: the golden model and comparator are present. After a complete 4-word capture, pass=1 if all four words match, else fail=1.
- MATRIX_DRV_CHECK_EN not defined: no golden logic. pass is tied to 0. fail reflects only timeout and short_burst. Capture and res are unchanged.

## Structure
- Package matrix_drv_pkg holds:
  - the state enum;
  - FRAME_BYTES=9, RESULT_WORDS=4, ELEM_W=8, RES_W=17;
  - the rotation-code constants.
- Sub-module matrix_rot_golden, instantiated only under MATRIX_DRV_CHECK_EN: a combinational rotation plus 2x2 multiply.
  - Inputs: latched rot_a, rot_b, mat_a, mat_b.
  - Output: 68-bit expected result vector, same packing as res.

## Test plan
- Identity: rot 0/0, A=[1,2,3,4], B=[5,6,7,8]. Expect tx bytes 00,01,02,03,04,05,06,07,08. Responder returns 19,22,43,50 → res matches, pass=1, done after 1 cycle.
- Rotate A: rot_a=1, rot_b=0, same matrices. Expect byte 0 = 04. Golden 22,26,34,40: a correct response gives pass=1; a response of 19,22,43,50 gives fail=1, pass=0.
- Max values: rot 3/3, all elements 255. Expect byte 0 = 0F; golden is 130050 for all four words, pass=1.
- Timeout: no rx_valid after frame. timeout=1 and fail=1, with done 64 cycles after the last byte plus 1 cycle.
- Short burst: rx_valid for 2 cycles (19,22), then low. short_burst=1, fail=1, res[33:0] holds 19,22, res[67:34]=0.
- Mid-frame reset and busy start: rst asserted during byte 4 → tx_valid=0 at once and all outputs 0. After release, a start pulse during a subsequent SEND is ignored and the frame byte count stays at 9.
